regfile_dump_unit: RTL and testbench
====================================

REGFILE_DUMP_UNIT -- requirements
Module: regfile_dump_unit

Interface
REQ-001 Parameter XLEN, 32, register data width in bits.
REQ-002 Parameter NREGS, 32, number of architectural registers scanned (2..64).
REQ-003 Parameter WDOG_CYCLES, 200, run-cycle limit before forced dump; 0 disables the watchdog.
REQ-004 Parameter ZERO_X0, 1, when 1, index 0 is reported as 0 regardless of rf_rdata.
REQ-005 Local IDXW = max(1, clog2(NREGS)).
REQ-006 Port clk  input  1  single clock, all logic on rising edge; one clock, no other clock domains.
REQ-007 Port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-008 Port halt_req  input  1  core end-of-program indication (ecall/tohost write), level or pulse.
REQ-009 Port core_stall  output  1  freezes core pipeline and register-file writes.
REQ-010 Port rf_raddr  output  IDXW  register-file read address (combinational read port).
REQ-011 Port rf_rdata  input  XLEN  register-file read data for rf_raddr, same cycle.
REQ-012 Port dump_valid  output  1  dump beat valid.
REQ-013 Port dump_ready  input  1  consumer accepts beat.
REQ-014 Port dump_idx  output  IDXW  register index of current beat.
REQ-015 Port dump_data  output  XLEN  register value of current beat.
REQ-016 Port dump_last  output  1  current beat is index NREGS-1.
REQ-017 Port done  output  1  sticky, all NREGS beats transferred.
REQ-018 Port timeout  output  1  sticky, dump was triggered by the watchdog, not halt_req.
REQ-019 Port run_cycles  output  32  cycles spent in RUN, saturating at 0xFFFF_FFFF.

Function
REQ-020 FSM states RUN, SCAN, DONE; reset state RUN.
REQ-021 RUN: run_cycles increments by 1 per cycle (saturating); core_stall=0; dump_valid=0.
REQ-022 RUN -> SCAN on halt_req=1; timeout stays 0.
REQ-023 RUN -> SCAN when WDOG_CYCLES!=0 and run_cycles==WDOG_CYCLES-1 with halt_req=0; timeout set to 1 on that edge.
REQ-024 halt_req and watchdog expiry in the same cycle: halt wins, timeout stays 0.
REQ-025 run_cycles freezes at its value on leaving RUN (the transition cycle is counted).
REQ-026 SCAN and DONE: core_stall=1, continuously.
REQ-027 SCAN: dump_valid=1 every cycle; rf_raddr=dump_idx; dump_data=rf_rdata, or 0 when ZERO_X0=1 and dump_idx==0.
REQ-028 SCAN entry: dump_idx=0 on first SCAN cycle.
REQ-029 Transfer occurs when dump_valid & dump_ready; dump_idx increments by 1 on transfer.
REQ-030 No transfer (dump_ready=0): dump_idx, dump_data, dump_last held stable; valid not withdrawn.
REQ-031 dump_last=1 exactly when in SCAN and dump_idx==NREGS-1.
REQ-032 Transfer with dump_last=1 -> DONE next cycle; dump_idx does not wrap and holds NREGS-1.
REQ-033 Minimum dump latency: NREGS cycles from first SCAN cycle to DONE with dump_ready held 1.
REQ-034 DONE: done=1, dump_valid=0, terminal until reset; halt_req ignored in SCAN and DONE.
REQ-035 rf_raddr in RUN driven 0; no effect on the core's own read ports.

Reset
REQ-036 rst_n=0 at a rising edge forces, next cycle: state RUN, run_cycles=0, dump_idx=0, done=0, timeout=0, dump_valid=0, dump_last=0, core_stall=0, rf_raddr=0.
REQ-037 dump_data while dump_valid=0 is don't-care.
REQ-038 Reset mid-SCAN or in DONE aborts the dump, no further beats; next trigger restarts at index 0.
REQ-039 Reset has priority over halt_req and watchdog expiry in the same cycle.

Verification
REQ-040 Halt path: NREGS=32, halt_req pulse at run cycle 50, dump_ready=1 -> 32 beats idx 0..31, idx0 data 0, dump_last on beat 31, done after 32 cycles, timeout=0, run_cycles=51.
REQ-041 Watchdog: WDOG_CYCLES=200, halt_req never asserted -> SCAN entered after 200 RUN cycles, timeout=1, run_cycles=200, full 32-beat dump.
REQ-042 Backpressure: dump_ready random 30% duty -> every index 0..NREGS-1 exactly once, in order, data matching register-file model; outputs stable while stalled.
REQ-043 Collision: halt_req asserted in cycle run_cycles==WDOG_CYCLES-1 -> timeout=0.
REQ-044 Reset mid-dump: rst_n low after beat 10 -> no beat 11, outputs at reset values, second halt dumps from idx 0.
REQ-045 Parameter sweep: NREGS=16, XLEN=64, ZERO_X0=0, WDOG_CYCLES=0 -> no watchdog trigger in 10000 cycles; halt dump returns rf_rdata for idx 0, 16 beats.

Source files
------------

// File: rtl/regfile_dump_unit.sv
// End-of-program register dump: freezes the core on halt or watchdog expiry, then
// streams every architectural register out over a valid/ready channel, one per beat.
module regfile_dump_unit #(
    parameter int XLEN        = 32,
    parameter int NREGS       = 32,
    parameter int WDOG_CYCLES = 200,
    parameter int ZERO_X0     = 1,
    localparam int IDXW       = ($clog2(NREGS) > 1) ? $clog2(NREGS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt_req,
    output logic            core_stall,
    output logic [IDXW-1:0] rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [IDXW-1:0] dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_last,
    output logic            done,
    output logic            timeout,
    output logic [31:0]     run_cycles
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SCAN,
        ST_DONE
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);

    state_t          state_reg, state_next;
    logic [31:0]     run_cycles_reg, run_cycles_next;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic            timeout_reg, timeout_next;
    logic            wdog_hit;
    logic            in_scan;
    logic            at_last;

    // Expiry fires on the last counted RUN cycle so the transition edge lands on WDOG_CYCLES.
    generate
        if (WDOG_CYCLES != 0) begin : g_wdog
            localparam logic [31:0] WDOG_LIMIT = 32'(WDOG_CYCLES - 1);
            assign wdog_hit = (run_cycles_reg == WDOG_LIMIT);
        end else begin : g_no_wdog
            assign wdog_hit = 1'b0;
        end
    endgenerate

    assign in_scan = (state_reg == ST_SCAN);
    assign at_last = (idx_reg == LAST_IDX);

    always_comb begin
        state_next      = state_reg;
        run_cycles_next = run_cycles_reg;
        idx_next        = idx_reg;
        timeout_next    = timeout_reg;
        case (state_reg)
            ST_RUN: begin
                idx_next = '0;
                if (run_cycles_reg != 32'hFFFF_FFFF) begin
                    run_cycles_next = run_cycles_reg + 32'd1;
                end
                // Halt takes priority, so a coincident expiry is not reported as a timeout.
                if (halt_req) begin
                    state_next = ST_SCAN;
                end else if (wdog_hit) begin
                    state_next   = ST_SCAN;
                    timeout_next = 1'b1;
                end
            end
            ST_SCAN: begin
                if (dump_ready) begin
                    if (at_last) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_RUN;
            run_cycles_reg <= '0;
            idx_reg        <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            run_cycles_reg <= run_cycles_next;
            idx_reg        <= idx_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign core_stall = (state_reg != ST_RUN);
    assign dump_valid = in_scan;
    assign rf_raddr   = in_scan ? idx_reg : '0;
    assign dump_idx   = idx_reg;
    assign dump_last  = in_scan && at_last;
    assign done       = (state_reg == ST_DONE);
    assign timeout    = timeout_reg;
    assign run_cycles = run_cycles_reg;
    assign dump_data  = ((ZERO_X0 != 0) && (idx_reg == '0)) ? '0 : rf_rdata;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: default instance (32x32, watchdog 200, x0 zeroed)
// plus a 16x64 instance with watchdog disabled and x0 passed through.
module tb_regfile_dump_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt_req, dump_ready;
    logic        core_stall, dump_valid, dump_last, done, timeout;
    logic [4:0]  rf_raddr, dump_idx;
    logic [31:0] rf_rdata, dump_data, run_cycles;

    logic        halt2, ready2;
    logic        core_stall2, valid2, last2, done2, timeout2;
    logic [3:0]  raddr2, idx2;
    logic [63:0] rdata2, data2;
    logic [31:0] run_cycles2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rf32(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'd7 + 32'd3;
    endfunction

    function automatic logic [63:0] rf64(input int i);
        return {32'hFACE_0000 + 32'(i), 32'h1234_0000 + 32'(i) * 32'd5 + 32'd9};
    endfunction

    assign rf_rdata = rf32(int'(rf_raddr));
    assign rdata2   = rf64(int'(raddr2));

    regfile_dump_unit u_dut (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .core_stall(core_stall),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_last(dump_last), .done(done), .timeout(timeout), .run_cycles(run_cycles)
    );

    regfile_dump_unit #(.XLEN(64), .NREGS(16), .WDOG_CYCLES(0), .ZERO_X0(0)) u_sweep (
        .clk(clk), .rst_n(rst_n), .halt_req(halt2), .core_stall(core_stall2),
        .rf_raddr(raddr2), .rf_rdata(rdata2), .dump_valid(valid2),
        .dump_ready(ready2), .dump_idx(idx2), .dump_data(data2),
        .dump_last(last2), .done(done2), .timeout(timeout2), .run_cycles(run_cycles2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; halt_req = 1'b0; dump_ready = 1'b0; halt2 = 1'b0; ready2 = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (dump_valid !== 1'b0 || core_stall !== 1'b0 || dump_idx !== 5'd0 || done !== 1'b0 ||
            timeout !== 1'b0 || dump_last !== 1'b0 || rf_raddr !== 5'd0 || run_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b stall=%b idx=%0d done=%b to=%b last=%b raddr=%0d run=%0d, required all zero",
                     dump_valid, core_stall, dump_idx, done, timeout, dump_last, rf_raddr, run_cycles);
        end
    endtask

    task automatic test_halt();
        logic [31:0] exp;
        apply_reset();
        repeat (50) step();
        checks++;
        if (run_cycles !== 32'd50 || core_stall !== 1'b0 || dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_pre: run=%0d stall=%b valid=%b, required run=50 stall=0 valid=0",
                     run_cycles, core_stall, dump_valid);
        end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        dump_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp = (k == 0) ? 32'd0 : rf32(k);
            checks++;
            if (dump_valid !== 1'b1 || dump_idx !== 5'(k) || dump_data !== exp ||
                dump_last !== (k == 31) || core_stall !== 1'b1 || rf_raddr !== 5'(k)) begin
                errors++;
                $display("FAIL halt_beat%0d: valid=%b idx=%0d raddr=%0d data=%h last=%b stall=%b, required valid=1 idx=%0d data=%h last=%b stall=1",
                         k, dump_valid, dump_idx, rf_raddr, dump_data, dump_last, core_stall, k, exp, (k == 31));
            end
            $display("halt beat idx=%0d data=%h last=%b", dump_idx, dump_data, dump_last);
            step();
        end
        dump_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || dump_valid !== 1'b0 || dump_idx !== 5'd31 || dump_last !== 1'b0 ||
            timeout !== 1'b0 || run_cycles !== 32'd51 || core_stall !== 1'b1) begin
            errors++;
            $display("FAIL halt_done: done=%b valid=%b idx=%0d last=%b to=%b run=%0d stall=%b, required 1 0 31 0 0 51 1",
                     done, dump_valid, dump_idx, dump_last, timeout, run_cycles, core_stall);
        end
        halt_req = 1'b1;
        step();
        step();
        halt_req = 1'b0;
        checks++;
        if (done !== 1'b1 || dump_valid !== 1'b0 || core_stall !== 1'b1) begin
            errors++;
            $display("FAIL done_terminal: done=%b valid=%b stall=%b, required 1 0 1", done, dump_valid, core_stall);
        end
    endtask

    task automatic test_watchdog_backpressure();
        logic [31:0] exp;
        logic        r;
        int          k;
        bit          finished;
        apply_reset();
        repeat (199) step();
        checks++;
        if (core_stall !== 1'b0 || run_cycles !== 32'd199 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL wdog_pre: stall=%b run=%0d to=%b, required 0 199 0", core_stall, run_cycles, timeout);
        end
        step();
        checks++;
        if (timeout !== 1'b1 || run_cycles !== 32'd200 || dump_valid !== 1'b1 || dump_idx !== 5'd0) begin
            errors++;
            $display("FAIL wdog_fire: to=%b run=%0d valid=%b idx=%0d, required 1 200 1 0",
                     timeout, run_cycles, dump_valid, dump_idx);
        end
        k = 0;
        finished = 1'b0;
        for (int c = 0; c < 2000 && !finished; c++) begin
            exp = (k == 0) ? 32'd0 : rf32(k);
            checks++;
            if (dump_valid !== 1'b1 || dump_idx !== 5'(k) || dump_data !== exp || dump_last !== (k == 31)) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b idx=%0d data=%h last=%b, required valid=1 idx=%0d data=%h last=%b",
                         c, dump_valid, dump_idx, dump_data, dump_last, k, exp, (k == 31));
            end
            r = ($urandom_range(0, 9) < 3);
            dump_ready = r;
            step();
            if (r) begin
                $display("bp beat idx=%0d accepted", k);
                if (k == 31) finished = 1'b1;
                else k++;
            end
        end
        dump_ready = 1'b0;
        checks++;
        if (!finished || done !== 1'b1 || dump_valid !== 1'b0 || timeout !== 1'b1 || run_cycles !== 32'd200) begin
            errors++;
            $display("FAIL bp_done: finished=%0d done=%b valid=%b to=%b run=%0d, required 1 1 0 1 200",
                     finished, done, dump_valid, timeout, run_cycles);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        repeat (199) step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++;
        if (timeout !== 1'b0 || dump_valid !== 1'b1 || run_cycles !== 32'd200) begin
            errors++;
            $display("FAIL collision: to=%b valid=%b run=%0d, required 0 1 200", timeout, dump_valid, run_cycles);
        end
    endtask

    task automatic test_reset_mid_dump();
        logic [31:0] exp;
        apply_reset();
        repeat (5) step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        dump_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            exp = (k == 0) ? 32'd0 : rf32(k);
            checks++;
            if (dump_valid !== 1'b1 || dump_idx !== 5'(k) || dump_data !== exp) begin
                errors++;
                $display("FAIL mid_beat%0d: valid=%b idx=%0d data=%h, required valid=1 idx=%0d data=%h",
                         k, dump_valid, dump_idx, dump_data, k, exp);
            end
            $display("mid beat idx=%0d data=%h", dump_idx, dump_data);
            step();
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (dump_valid !== 1'b0 || dump_idx !== 5'd0 || core_stall !== 1'b0 || run_cycles !== 32'd0 ||
            dump_last !== 1'b0 || rf_raddr !== 5'd0 || done !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b idx=%0d stall=%b run=%0d last=%b raddr=%0d done=%b to=%b, required all zero",
                     dump_valid, dump_idx, core_stall, run_cycles, dump_last, rf_raddr, done, timeout);
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (dump_valid !== 1'b0 || run_cycles !== 32'd3) begin
            errors++;
            $display("FAIL mid_nobeat: valid=%b run=%0d, required valid=0 run=3", dump_valid, run_cycles);
        end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++;
        if (dump_valid !== 1'b1 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
            errors++;
            $display("FAIL mid_restart: valid=%b idx=%0d data=%h, required valid=1 idx=0 data=0",
                     dump_valid, dump_idx, dump_data);
        end
        dump_ready = 1'b0;
    endtask

    task automatic test_sweep();
        logic [63:0] exp;
        apply_reset();
        repeat (10000) step();
        checks++;
        if (core_stall2 !== 1'b0 || valid2 !== 1'b0 || timeout2 !== 1'b0 || run_cycles2 !== 32'd10000) begin
            errors++;
            $display("FAIL sweep_nowdog: stall=%b valid=%b to=%b run=%0d, required 0 0 0 10000",
                     core_stall2, valid2, timeout2, run_cycles2);
        end
        halt2 = 1'b1;
        step();
        halt2 = 1'b0;
        ready2 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = rf64(k);
            checks++;
            if (valid2 !== 1'b1 || idx2 !== 4'(k) || data2 !== exp || last2 !== (k == 15)) begin
                errors++;
                $display("FAIL sweep_beat%0d: valid=%b idx=%0d data=%h last=%b, required valid=1 idx=%0d data=%h last=%b",
                         k, valid2, idx2, data2, last2, k, exp, (k == 15));
            end
            $display("sweep beat idx=%0d data=%h last=%b", idx2, data2, last2);
            step();
        end
        ready2 = 1'b0;
        checks++;
        if (done2 !== 1'b1 || valid2 !== 1'b0 || idx2 !== 4'd15 || timeout2 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done: done=%b valid=%b idx=%0d to=%b, required 1 0 15 0",
                     done2, valid2, idx2, timeout2);
        end
    endtask

    initial begin
        rst_n = 1'b0; halt_req = 1'b0; dump_ready = 1'b0; halt2 = 1'b0; ready2 = 1'b0;
        test_reset();
        test_halt();
        test_watchdog_backpressure();
        test_collision();
        test_reset_mid_dump();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
